l1_mem_arbiter: RTL and testbench
=================================

// Module: l1_mem_arbiter
// PURPOSE
// - Shares one single-ported L2/memory port (ram_cache_glue or memory_model, mem_* protocol) between I-cache and D-cache.
// - Sits between the two cache_module instances and the downstream memory.
// - Round-robin, grant held for a requester's whole miss sequence (writeback + fill); per-port perf counters.
// PARAMETERS
// - BLOCKS  4   32-bit words per cache block (matches cache_module)
// - CNT_W   32  width of each saturating perf counter
// PORTS
// - clock               in   1            single clock, all state on posedge
// - reset               in   1            synchronous, active-low (0 = reset)
// - i_mem_req           in   1            I-cache memory request, held until done
// - i_mem_we            in   1            I-cache writeback (1) / fill (0)
// - i_mem_addr          in   32           I-cache block address
// - i_mem_write_block   in   BLOCKS*32    I-cache writeback data
// - i_mem_read_block    out  BLOCKS*32    fill data to I-cache
// - i_mem_miss          out  1            1 = I-cache transaction not complete
// - d_mem_*             same set as i_mem_*, for the D-cache
// - mem_req, mem_we, mem_addr, mem_write_block   out   to downstream memory
// - mem_read_block      in   BLOCKS*32    downstream fill data
// - mem_miss            in   1            downstream busy; req & !miss = done
// - i_grant_cnt, d_grant_cnt  out  CNT_W  grants issued per port
// - i_wait_cnt, d_wait_cnt    out  CNT_W  cycles req high but not granted
// BEHAVIOUR
// - FSM arb_state_t: IDLE, GNT_I, GNT_D; registered. last_gnt bit (0=I, 1=D).
// - IDLE: only i_req -> GNT_I; only d_req -> GNT_D; both -> port != last_gnt.
// - GNT_x: x_mem_req=1 -> stay (lock spans addr/we changes, so writeback then fill is atomic).
// - GNT_x: x_mem_req=0 -> other req high ? GNT_other : IDLE. last_gnt := x on leave.
// - Downstream: mem_req = x_mem_req & (state==GNT_x); mem_we/addr/write_block muxed from granted port; all 0 in IDLE.
// - Arbitration latency: req seen in IDLE at edge N -> mem_req high in cycle N+1. No combinational req->mem_req path from IDLE.
// - Granted port: x_mem_miss = mem_miss (pass-through, 0 latency). x_mem_read_block = mem_read_block.
// - Non-granted / IDLE port: x_mem_miss = x_mem_req (1 while waiting, 0 when idle). read_block = 0.
// - Release cycle (granted req low): mem_req = 0, so downstream sees >=1 idle cycle between owners.
// - Counters: grant_cnt +1 on each entry to GNT_x; wait_cnt +1 each cycle x_req & state!=GNT_x. Saturate at all-ones.
// - Reset (reset==0 at posedge, incl. mid-transaction): state=IDLE, last_gnt=1 (I wins first tie), counters=0.
// - Post-reset outputs: mem_req=0, mem_we=0, mem_addr=0, write_block=0; x_mem_miss = x_mem_req; read_blocks=0.
// - Mid-transaction reset aborts; downstream must tolerate mem_req drop. No reset-time write completion guaranteed.
// - Downstream mem_miss while no grant: ignored.
// STRUCTURE
// - cache_types package: add arb_state_t enum {IDLE,GNT_I,GNT_D}, arb_port_e {PORT_I=0,PORT_D=1}.
// - Sub-module arb_rr2: holds last_gnt, inputs req[1:0] + release, outputs next grant. FSM + mux + counters stay in the top.
// TESTING
// - Only i_req (we=0, addr=0x100), mem_miss 3 cycles -> mem_req at N+1, mem_addr=0x100, i_miss=1 until done, i_grant_cnt=1.
// - i_req and d_req same cycle after reset -> I granted first, d_miss=1 throughout.
// - After I completes, D granted with exactly one mem_req=0 cycle between; next tie -> D loses? no: last_gnt=I so D wins.
// - D writeback (we=1, addr=0x200) then fill (we=0, addr=0x300) while i_req held -> D keeps grant across both; I never interleaves.
// - I-cache waits 5 cycles behind D -> i_wait_cnt=5, d_wait_cnt=0.
// - Reset pulled low while GNT_D with mem_miss=1 -> next cycle state IDLE, mem_req=0, all counters 0.

Source files
------------

// File: rtl/cache_types.sv
// Types shared by the L1 cache side of the memory hierarchy.
// Arbiter state and port encodings are used by l1_mem_arbiter and arb_rr2.
package cache_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

    function automatic arb_state_t gnt_state(input arb_port_e port);
        return (port == PORT_D) ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin chooser: remembers the last port to release the
// memory and picks the other one when both request together.
module arb_rr2
    import cache_types::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       rel_i,
    input  arb_port_e  rel_port_i,
    output logic       gnt_valid_o,
    output arb_port_e  gnt_port_o
);

    arb_port_e last_gnt_q;
    arb_port_e last_gnt_d;

    always_comb begin
        last_gnt_d = rel_i ? rel_port_i : last_gnt_q;
    end

    // Reset to D so that the I-cache wins the first tie.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            last_gnt_q <= PORT_D;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        gnt_valid_o = |req_i;
        gnt_port_o  = PORT_I;
        if (req_i == 2'b10) begin
            gnt_port_o = PORT_D;
        end else if (req_i == 2'b11) begin
            if (last_gnt_q == PORT_I) begin
                gnt_port_o = PORT_D;
            end else begin
                gnt_port_o = PORT_I;
            end
        end
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one single-ported memory between the I-cache and D-cache; a grant
// is held for a requester's whole miss sequence (writeback then fill).
module l1_mem_arbiter
    import cache_types::*;
#(
    parameter int unsigned BLOCKS = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_mem_req,
    input  logic                   i_mem_we,
    input  logic [31:0]            i_mem_addr,
    input  logic [BLOCKS*32-1:0]   i_mem_write_block,
    output logic [BLOCKS*32-1:0]   i_mem_read_block,
    output logic                   i_mem_miss,
    input  logic                   d_mem_req,
    input  logic                   d_mem_we,
    input  logic [31:0]            d_mem_addr,
    input  logic [BLOCKS*32-1:0]   d_mem_write_block,
    output logic [BLOCKS*32-1:0]   d_mem_read_block,
    output logic                   d_mem_miss,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [BLOCKS*32-1:0]   mem_write_block,
    input  logic [BLOCKS*32-1:0]   mem_read_block,
    input  logic                   mem_miss,
    output logic [CNT_W-1:0]       i_grant_cnt,
    output logic [CNT_W-1:0]       d_grant_cnt,
    output logic [CNT_W-1:0]       i_wait_cnt,
    output logic [CNT_W-1:0]       d_wait_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t state_q, state_d;
    logic [1:0] arb_req;
    logic       rel;
    arb_port_e  rel_port;
    logic       nxt_valid;
    arb_port_e  nxt_port;

    logic [CNT_W-1:0] i_grant_q, i_grant_d;
    logic [CNT_W-1:0] d_grant_q, d_grant_d;
    logic [CNT_W-1:0] i_wait_q, i_wait_d;
    logic [CNT_W-1:0] d_wait_q, d_wait_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && !(&v)) begin
            return v + CNT_ONE;
        end
        return v;
    endfunction

    arb_rr2 u_rr (
        .clock       (clock),
        .reset       (reset),
        .req_i       (arb_req),
        .rel_i       (rel),
        .rel_port_i  (rel_port),
        .gnt_valid_o (nxt_valid),
        .gnt_port_o  (nxt_port)
    );

    // The owner's own request is masked on release, so the chooser can only
    // hand over to the other port or fall back to IDLE.
    always_comb begin
        state_d  = state_q;
        arb_req  = 2'b00;
        rel      = 1'b0;
        rel_port = PORT_I;
        case (state_q)
            IDLE: begin
                arb_req = {d_mem_req, i_mem_req};
                if (nxt_valid) begin
                    state_d = gnt_state(nxt_port);
                end
            end
            GNT_I: begin
                if (!i_mem_req) begin
                    rel      = 1'b1;
                    rel_port = PORT_I;
                    arb_req  = {d_mem_req, 1'b0};
                    state_d  = nxt_valid ? gnt_state(nxt_port) : IDLE;
                end
            end
            GNT_D: begin
                if (!d_mem_req) begin
                    rel      = 1'b1;
                    rel_port = PORT_D;
                    arb_req  = {1'b0, i_mem_req};
                    state_d  = nxt_valid ? gnt_state(nxt_port) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_grant_d = sat_inc(i_grant_q, (state_d == GNT_I) && (state_q != GNT_I));
        d_grant_d = sat_inc(d_grant_q, (state_d == GNT_D) && (state_q != GNT_D));
        i_wait_d  = sat_inc(i_wait_q, i_mem_req && (state_q != GNT_I));
        d_wait_d  = sat_inc(d_wait_q, d_mem_req && (state_q != GNT_D));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            i_grant_q <= '0;
            d_grant_q <= '0;
            i_wait_q  <= '0;
            d_wait_q  <= '0;
        end else begin
            state_q   <= state_d;
            i_grant_q <= i_grant_d;
            d_grant_q <= d_grant_d;
            i_wait_q  <= i_wait_d;
            d_wait_q  <= d_wait_d;
        end
    end

    // mem_req follows the owner's request so a release cycle shows mem_req=0;
    // a waiting port sees miss=1 until it is granted.
    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_write_block  = '0;
        i_mem_miss       = i_mem_req;
        d_mem_miss       = d_mem_req;
        i_mem_read_block = '0;
        d_mem_read_block = '0;
        case (state_q)
            GNT_I: begin
                mem_req          = i_mem_req;
                mem_we           = i_mem_we;
                mem_addr         = i_mem_addr;
                mem_write_block  = i_mem_write_block;
                i_mem_miss       = mem_miss;
                i_mem_read_block = mem_read_block;
            end
            GNT_D: begin
                mem_req          = d_mem_req;
                mem_we           = d_mem_we;
                mem_addr         = d_mem_addr;
                mem_write_block  = d_mem_write_block;
                d_mem_miss       = mem_miss;
                d_mem_read_block = mem_read_block;
            end
            default: ;
        endcase
    end

    assign i_grant_cnt = i_grant_q;
    assign d_grant_cnt = d_grant_q;
    assign i_wait_cnt  = i_wait_q;
    assign d_wait_cnt  = d_wait_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: single-cycle vector table plus multi-cycle
// sequences against a latency-programmable memory model and a scoreboard.
module tb_l1_mem_arbiter;

    localparam int BLOCKS = 4;
    localparam int CNT_W  = 4;
    localparam int BW     = BLOCKS * 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          i_mem_req, i_mem_we, d_mem_req, d_mem_we;
    logic [31:0]   i_mem_addr, d_mem_addr, mem_addr;
    logic [BW-1:0] i_mem_write_block, d_mem_write_block, mem_write_block;
    logic [BW-1:0] i_mem_read_block, d_mem_read_block, mem_read_block;
    logic          i_mem_miss, d_mem_miss, mem_req, mem_we, mem_miss;
    logic [CNT_W-1:0] i_grant_cnt, d_grant_cnt, i_wait_cnt, d_wait_cnt;

    function automatic logic [BW-1:0] rb_of(input logic [31:0] a);
        return {BLOCKS{a ^ 32'hA5A5_0000}};
    endfunction

    function automatic logic [BW-1:0] wb_of(input logic is_d, input logic [31:0] a);
        return {BLOCKS{(is_d ? 32'h2000_0000 : 32'h1000_0000) | a}};
    endfunction

    assign i_mem_write_block = wb_of(1'b0, i_mem_addr);
    assign d_mem_write_block = wb_of(1'b1, d_mem_addr);
    assign mem_read_block    = rb_of(mem_addr);

    // Memory model: busy for mem_lat cycles after a request starts, then one done cycle.
    logic        mem_auto;
    logic        mem_miss_man;
    int unsigned mem_lat;
    int unsigned busy_q = 0;
    always @(posedge clock) begin
        if (!mem_req)         busy_q <= mem_lat;
        else if (busy_q != 0) busy_q <= busy_q - 1;
        else                  busy_q <= mem_lat;
    end
    assign mem_miss = mem_auto ? (mem_req && busy_q != 0) : mem_miss_man;

    l1_mem_arbiter #(.BLOCKS(BLOCKS), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
        .i_mem_write_block(i_mem_write_block), .i_mem_read_block(i_mem_read_block),
        .i_mem_miss(i_mem_miss),
        .d_mem_req(d_mem_req), .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr),
        .d_mem_write_block(d_mem_write_block), .d_mem_read_block(d_mem_read_block),
        .d_mem_miss(d_mem_miss),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_block(mem_write_block), .mem_read_block(mem_read_block),
        .mem_miss(mem_miss),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt),
        .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        port;
        logic        we;
        logic [31:0] addr;
    } txn_t;
    txn_t sb_q[$];

    // Completion monitor: req & !miss is a finished downstream transaction.
    always @(negedge clock) begin : mon
        txn_t got;
        txn_t exp;
        if (mem_auto && reset && mem_req && !mem_miss) begin
            got.port = (d_mem_read_block != '0);
            got.we   = mem_we;
            got.addr = mem_addr;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected none", got);
            end else begin
                exp = sb_q.pop_front();
                check("sb_txn", BW'(got), BW'(exp));
            end
        end
    end

    task automatic to_drive();
        @(posedge clock);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_addr = '0;
        d_mem_req = 1'b0; d_mem_we = 1'b0; d_mem_addr = '0;
    endtask

    // Ends at the drive point of the first cycle after reset.
    task automatic do_reset();
        to_drive();
        clear_inputs();
        reset = 1'b0;
        to_drive();
        reset = 1'b1;
    endtask

    // From a sample point, step until the port's miss clears (bounded).
    task automatic wait_done(input logic is_d, input logic watch_other, output int n, inout int bad);
        n = 0;
        while (((is_d ? d_mem_miss : i_mem_miss) == 1'b1) && n < 40) begin
            if (watch_other && ((is_d ? i_mem_miss : d_mem_miss) != 1'b1)) bad++;
            n++;
            to_drive();
            to_sample();
        end
    endtask

    typedef enum logic [1:0] {SRC_NONE, SRC_I, SRC_D} src_e;
    typedef struct {
        logic        i_req;
        logic        i_we;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic        miss;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_imiss;
        logic        e_dmiss;
        src_e        e_src;
    } vec_t;

    vec_t vecs[6];
    logic [BW-1:0] e_wb, e_irb, e_drb;
    int n, bad;
    logic [CNT_W-1:0] iw0, dw0, dg0;

    initial begin
        reset = 1'b0;
        clear_inputs();
        mem_auto = 1'b0; mem_miss_man = 1'b0; mem_lat = 3;

        vecs[0] = '{1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, SRC_I};
        vecs[1] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, SRC_D};
        vecs[2] = '{1'b1, 1'b1, 32'h140, 1'b1, 1'b0, 32'h240, 1'b0, 1'b1, 1'b1, 32'h140, 1'b0, 1'b1, SRC_I};
        vecs[3] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, SRC_NONE};
        vecs[4] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h2C0, 1'b0, 1'b1, 1'b0, 32'h2C0, 1'b0, 1'b0, SRC_D};
        vecs[5] = '{1'b1, 1'b1, 32'h1C0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h1C0, 1'b0, 1'b0, SRC_I};

        // Reset state
        do_reset();
        to_sample();
        check("rst_mem_req", BW'(mem_req), BW'(0));
        check("rst_mem_we", BW'(mem_we), BW'(0));
        check("rst_mem_addr", BW'(mem_addr), BW'(0));
        check("rst_mem_wb", mem_write_block, '0);
        check("rst_i_miss", BW'(i_mem_miss), BW'(0));
        check("rst_d_rb", d_mem_read_block, '0);
        check("rst_cnts", BW'({i_grant_cnt, d_grant_cnt, i_wait_cnt, d_wait_cnt}), BW'(0));

        // Single-step vectors from a fresh reset
        for (int k = 0; k < 6; k++) begin
            do_reset();
            i_mem_req = vecs[k].i_req; i_mem_we = vecs[k].i_we; i_mem_addr = vecs[k].i_addr;
            d_mem_req = vecs[k].d_req; d_mem_we = vecs[k].d_we; d_mem_addr = vecs[k].d_addr;
            mem_miss_man = vecs[k].miss;
            #1;
            check($sformatf("tv%0d_idle_req", k), BW'(mem_req), BW'(0));
            check($sformatf("tv%0d_idle_imiss", k), BW'(i_mem_miss), BW'(vecs[k].i_req));
            to_drive();
            to_sample();
            e_wb  = (vecs[k].e_src == SRC_I) ? wb_of(1'b0, vecs[k].e_addr) :
                    (vecs[k].e_src == SRC_D) ? wb_of(1'b1, vecs[k].e_addr) : '0;
            e_irb = (vecs[k].e_src == SRC_I) ? rb_of(vecs[k].e_addr) : '0;
            e_drb = (vecs[k].e_src == SRC_D) ? rb_of(vecs[k].e_addr) : '0;
            check($sformatf("tv%0d_req", k), BW'(mem_req), BW'(vecs[k].e_req));
            check($sformatf("tv%0d_we", k), BW'(mem_we), BW'(vecs[k].e_we));
            check($sformatf("tv%0d_addr", k), BW'(mem_addr), BW'(vecs[k].e_addr));
            check($sformatf("tv%0d_wb", k), mem_write_block, e_wb);
            check($sformatf("tv%0d_imiss", k), BW'(i_mem_miss), BW'(vecs[k].e_imiss));
            check($sformatf("tv%0d_dmiss", k), BW'(d_mem_miss), BW'(vecs[k].e_dmiss));
            check($sformatf("tv%0d_irb", k), i_mem_read_block, e_irb);
            check($sformatf("tv%0d_drb", k), d_mem_read_block, e_drb);
        end

        // I-cache alone: grant one cycle later, three busy cycles
        mem_auto = 1'b1;
        mem_lat  = 3;
        do_reset();
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h100;
        sb_q.push_back('{1'b0, 1'b0, 32'h100});
        #1;
        check("a_idle_memreq", BW'(mem_req), BW'(0));
        check("a_idle_imiss", BW'(i_mem_miss), BW'(1));
        to_drive();
        to_sample();
        check("a_memreq", BW'(mem_req), BW'(1));
        check("a_addr", BW'(mem_addr), BW'(32'h100));
        bad = 0;
        wait_done(1'b0, 1'b0, n, bad);
        check("a_miss_cycles", BW'(n), BW'(3));
        check("a_i_grant", BW'(i_grant_cnt), BW'(1));
        to_drive();
        i_mem_req = 1'b0;
        to_sample();
        check("a_release_req", BW'(mem_req), BW'(0));

        // Tie with last grant = I: D wins and holds through writeback + fill
        to_drive();
        mem_lat = 1;
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h140;
        d_mem_req = 1'b1; d_mem_we = 1'b1; d_mem_addr = 32'h200;
        sb_q.push_back('{1'b1, 1'b1, 32'h200});
        sb_q.push_back('{1'b1, 1'b0, 32'h300});
        sb_q.push_back('{1'b0, 1'b0, 32'h140});
        to_sample();
        check("c_idle_memreq", BW'(mem_req), BW'(0));
        to_drive();
        to_sample();
        check("c_tie_d_addr", BW'(mem_addr), BW'(32'h200));
        check("c_tie_d_we", BW'(mem_we), BW'(1));
        iw0 = i_wait_cnt; dw0 = d_wait_cnt; dg0 = d_grant_cnt;
        bad = 0;
        wait_done(1'b1, 1'b1, n, bad);
        to_drive();
        d_mem_we = 1'b0; d_mem_addr = 32'h300;
        to_sample();
        check("d_fill_req", BW'(mem_req), BW'(1));
        check("d_fill_addr", BW'(mem_addr), BW'(32'h300));
        wait_done(1'b1, 1'b1, n, bad);
        to_drive();
        d_mem_req = 1'b0;
        to_sample();
        check("d_release_gap", BW'(mem_req), BW'(0));
        check("d_release_imiss", BW'(i_mem_miss), BW'(1));
        to_drive();
        to_sample();
        check("e_i_addr", BW'({mem_req, mem_addr}), BW'({1'b1, 32'h140}));
        check("d_lock_no_interleave", BW'(bad), BW'(0));
        check("e_i_wait", BW'(i_wait_cnt), BW'(iw0 + 4'd5));
        check("e_d_wait", BW'(d_wait_cnt), BW'(dw0));
        check("d_grant_once", BW'(d_grant_cnt), BW'(dg0));
        check("e_i_grant", BW'(i_grant_cnt), BW'(2));
        wait_done(1'b0, 1'b0, n, bad);
        to_drive();
        i_mem_req = 1'b0;
        to_sample();

        // Tie straight after reset: I first, D waits, one idle cycle between
        mem_lat = 3;
        do_reset();
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h180;
        d_mem_req = 1'b1; d_mem_we = 1'b0; d_mem_addr = 32'h280;
        sb_q.push_back('{1'b0, 1'b0, 32'h180});
        sb_q.push_back('{1'b1, 1'b0, 32'h280});
        to_drive();
        to_sample();
        check("b_tie_i_addr", BW'(mem_addr), BW'(32'h180));
        bad = 0;
        wait_done(1'b0, 1'b1, n, bad);
        to_drive();
        i_mem_req = 1'b0;
        to_sample();
        check("b_gap_req", BW'(mem_req), BW'(0));
        check("b_gap_dmiss", BW'(d_mem_miss), BW'(1));
        to_drive();
        to_sample();
        check("b_d_granted", BW'({mem_req, mem_addr}), BW'({1'b1, 32'h280}));
        check("b_dmiss_held", BW'(bad), BW'(0));
        check("b_d_wait", BW'(d_wait_cnt), BW'(6));
        check("b_i_wait", BW'(i_wait_cnt), BW'(1));
        check("b_grants", BW'({i_grant_cnt, d_grant_cnt}), BW'({4'd1, 4'd1}));
        wait_done(1'b1, 1'b0, n, bad);
        to_drive();
        d_mem_req = 1'b0;
        to_sample();

        // Reset pulled while D owns the port with mem_miss=1
        do_reset();
        d_mem_req = 1'b1; d_mem_we = 1'b1; d_mem_addr = 32'h3C0;
        to_drive();
        to_sample();
        check("f_pre_busy", BW'({mem_req, d_mem_miss}), BW'(2'b11));
        to_drive();
        reset = 1'b0;
        to_sample();
        to_drive();
        reset = 1'b1;
        to_sample();
        check("f_req", BW'(mem_req), BW'(0));
        check("f_we_addr", BW'({mem_we, mem_addr}), BW'(0));
        check("f_wb", mem_write_block, '0);
        check("f_dmiss", BW'(d_mem_miss), BW'(1));
        check("f_drb", d_mem_read_block, '0);
        check("f_cnts", BW'({i_grant_cnt, d_grant_cnt, i_wait_cnt, d_wait_cnt}), BW'(0));
        to_drive();
        d_mem_req = 1'b0;
        to_sample();

        // Wait counter saturates at all-ones
        to_drive();
        mem_lat = 25;
        d_mem_req = 1'b1; d_mem_we = 1'b0; d_mem_addr = 32'h400;
        to_drive();
        i_mem_req = 1'b1; i_mem_addr = 32'h180;
        for (int c = 0; c < 20; c++) begin
            to_drive();
            to_sample();
        end
        check("g_i_wait_sat", BW'(i_wait_cnt), BW'(4'hF));
        check("g_i_still_waiting", BW'({i_mem_miss, mem_addr}), BW'({1'b1, 32'h400}));
        do_reset();
        to_sample();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
